// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {instruction, pc} between I-cache and decode.
// Optional same-cycle empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTR_W-1:0]           in_instruction,
  input  logic [ADDR_W-1:0]            in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTR_W-1:0]           out_instruction,
  output logic [ADDR_W-1:0]            out_pc,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = INSTR_W + ADDR_W;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_direct;
  logic w_enq;
  logic w_deq;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_empty & in_valid & ~flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed entry taken by the consumer in the same cycle never touches storage.
  assign w_direct = w_bypass & out_ready;
  assign w_enq    = in_valid & ~w_full & ~flush & ~w_direct;
  assign w_deq    = ~w_empty & out_ready & ~flush;

  assign in_ready = ~w_full;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;

  always_comb begin
    out_valid       = 1'b0;
    out_instruction = '0;
    out_pc          = '0;
    if (!w_empty) begin
      out_valid                 = 1'b1;
      {out_instruction, out_pc} = r_mem[r_head];
    end else if (w_bypass) begin
      out_valid       = 1'b1;
      out_instruction = in_instruction;
      out_pc          = in_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= next_ptr(r_tail);
      if (w_deq) r_head <= next_ptr(r_head);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; outputs are gated while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_tail] <= {in_instruction, in_pc};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int IW    = 32;
  localparam int AW    = 64;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instruction;
  logic [AW-1:0] in_pc;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instruction;
  logic [AW-1:0] out_pc;
  logic          flush;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  fetch_queue #(.DEPTH(DEPTH), .INSTR_W(IW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc(out_pc),
    .flush(flush), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of {instr, pc}.
  logic [IW+AW-1:0] mq[$];
  logic [AW-1:0]    dut_pops[$];

  function automatic logic model_bypass();
`ifdef FETCH_QUEUE_BYPASS_EN
    return (mq.size() == 0) && in_valid && !flush;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
    end else begin
      logic fl, rdy, dq, direct, eq;
      logic [IW+AW-1:0] ent;
      fl     = flush;
      rdy    = mq.size() < DEPTH;
      dq     = (mq.size() > 0) && out_ready && !fl;
      direct = model_bypass() && out_ready;
      eq     = in_valid && rdy && !fl && !direct;
      ent    = {in_instruction, in_pc};
      if (fl) mq.delete();
      else begin
        if (dq) void'(mq.pop_front());
        if (eq) mq.push_back(ent);
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle when inputs are stable.
  always @(negedge clk) begin
    if (!reset) begin
      logic          ev;
      logic [IW-1:0] ei;
      logic [AW-1:0] ep;
      ev = 1'b0; ei = '0; ep = '0;
      if (mq.size() > 0) begin
        ev = 1'b1;
        {ei, ep} = mq[0];
      end else if (model_bypass()) begin
        ev = 1'b1; ei = in_instruction; ep = in_pc;
      end
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("out_pc", out_pc, ep);
      chk("out_instruction", 64'(out_instruction), 64'(ei));
      chk("count", 64'(count), 64'(mq.size()));
      chk("full", 64'(full), 64'(mq.size() == DEPTH));
      chk("empty", 64'(empty), 64'(mq.size() == 0));
      chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
      if (out_valid && out_ready && !flush) dut_pops.push_back(out_pc);
    end
  end

  task automatic drive(input logic v, input logic [AW-1:0] pc, input logic [IW-1:0] ins,
                       input logic ordy, input logic fl);
    in_valid = v; in_pc = pc; in_instruction = ins; out_ready = ordy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_pc = '0; in_instruction = '0;
    #1;
  endtask

  logic [IW-1:0] ins3 [3] = '{32'h00000013, 32'h00100093, 32'h00200113};

  initial begin
    int idx, cyc;
    reset = 1'b1; in_valid = 0; out_ready = 0; flush = 0; in_pc = '0; in_instruction = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_instr", 64'(out_instruction), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: three pushes, then drain in order
    for (int i = 0; i < 3; i++) drive(1, 64'h1000 + 64'(4 * i), ins3[i], 0, 0);
    settle();
    chk("t1_count", 64'(count), 64'd3);
    chk("t1_head_pc", out_pc, 64'h1000);
    chk("t1_head_instr", 64'(out_instruction), 64'h00000013);
    dut_pops.delete();
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);
    settle();
    chk("t1_empty", 64'(empty), 64'd1);
    chk("t1_npops", 64'(dut_pops.size()), 64'd3);
    for (int i = 0; i < 3 && i < dut_pops.size(); i++)
      chk("t1_order", dut_pops[i], 64'h1000 + 64'(4 * i));

    // 2: fill, overflow attempt, drain
    for (int i = 0; i < 8; i++) drive(1, 64'h2000 + 64'(4 * i), 32'h100 + 32'(i), 0, 0);
    settle();
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_in_ready", 64'(in_ready), 64'd0);
    drive(1, 64'h2020, 32'hdead, 0, 0);
    settle();
    chk("t2_count", 64'(count), 64'd8);
    dut_pops.delete();
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 0);
    settle();
    chk("t2_npops", 64'(dut_pops.size()), 64'd8);
    for (int i = 0; i < 8 && i < dut_pops.size(); i++)
      chk("t2_order", dut_pops[i], 64'h2000 + 64'(4 * i));

    // 3: simultaneous push and pop at count 4
    for (int i = 0; i < 4; i++) drive(1, 64'h2100 + 64'(4 * i), 32'h200 + 32'(i), 0, 0);
    dut_pops.delete();
    drive(1, 64'h2110, 32'h204, 1, 0);
    settle();
    chk("t3_count", 64'(count), 64'd4);
    chk("t3_popped", (dut_pops.size() > 0) ? dut_pops[0] : 64'hx, 64'h2100);
    chk("t3_head", out_pc, 64'h2104);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0);

    // 4: streaming 20 entries with random backpressure
    dut_pops.delete();
    idx = 0; cyc = 0;
    while (dut_pops.size() < 20 && cyc < 400) begin
      logic acc;
      logic v;
      logic r;
      v   = (idx < 20);
      r   = 1'($urandom_range(0, 1));
      acc = v && (mq.size() < DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
      if (v && mq.size() == 0 && r) acc = 1'b1;
`endif
      drive(v, 64'h3000 + 64'(4 * idx), 32'h300 + 32'(idx), r, 0);
      if (acc) idx++;
      cyc++;
    end
    settle();
    chk("t4_npops", 64'(dut_pops.size()), 64'd20);
    for (int i = 0; i < 20 && i < dut_pops.size(); i++)
      chk("t4_order", dut_pops[i], 64'h3000 + 64'(4 * i));

    // 5: flush drops a same-cycle push
    for (int i = 0; i < 5; i++) drive(1, 64'h4100 + 64'(4 * i), 32'h400 + 32'(i), 0, 0);
    settle();
    chk("t5_count5", 64'(count), 64'd5);
    drive(1, 64'h4000, 32'h4000, 0, 1);
    settle();
    chk("t5_count0", 64'(count), 64'd0);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    drive(1, 64'h5000, 32'h5000, 0, 0);
    settle();
    chk("t5_pc", out_pc, 64'h5000);
    chk("t5_count1", 64'(count), 64'd1);
    drive(0, 0, 0, 1, 0);

    // 6: asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) drive(1, 64'h5100 + 64'(4 * i), 32'h500 + 32'(i), 0, 0);
    settle();
    chk("t6_count3", 64'(count), 64'd3);
    #2 reset = 1'b1;
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_out_pc", out_pc, 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

`ifdef FETCH_QUEUE_BYPASS_EN
    in_valid = 1; in_pc = 64'h6000; in_instruction = 32'h6000; out_ready = 1; flush = 0;
    #1;
    chk("byp_valid", 64'(out_valid), 64'd1);
    chk("byp_pc", out_pc, 64'h6000);
    @(posedge clk); #1;
    settle();
    chk("byp_count", 64'(count), 64'd0);
`endif

    settle();
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
